difftest_arch_event_queue: RTL
==============================

Name: difftest_arch_event_queue

Overview:
- Sits directly upstream of the difftest arch-event DPI sink.
- Captures raw trap reports from the CSR/trap unit and encodes them into the sink's interrupt/exception bundle.
- Buffers events in a small FIFO so that difftest transport backpressure never stalls the core.
- Drains one event per cycle into the sink's enable/io_* inputs.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- VADDR_BITS, 50, width of the incoming PC; sign-extended to 64 bits.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  trap report valid this cycle
- in_isInterrupt  in  1  1 = interrupt, 0 = exception
- in_cause  in  6  trap cause code
- in_pc  in  VADDR_BITS  trapping PC
- in_inst  in  32  trapping instruction encoding
- in_hasNMI  in  1  trap is an NMI
- in_hvictlInject  in  1  virtual interrupt was injected via hvictl
- in_irToHS  in  1  interrupt delegated to HS
- in_irToVS  in  1  interrupt delegated to VS
- in_coreid  in  8  hart id (static)
- out_ready  in  1  sink/transport accepts an event this cycle
- enable  out  1  event transferred this cycle (io_valid AND out_ready)
- io_valid  out  1  FIFO non-empty
- io_interrupt  out  32  encoded interrupt cause
- io_exception  out  32  encoded exception cause
- io_exceptionPC  out  64  sign-extended PC
- io_exceptionInst  out  32  instruction encoding
- io_hasNMI  out  1
- io_virtualInterruptIsHvictlInject  out  1
- io_irToHS  out  1
- io_irToVS  out  1
- io_coreid  out  8  passthrough of in_coreid
- overflow  out  1  sticky: at least one event was dropped
- drop_count  out  CNT_W  number of dropped events, saturating

Behaviour:
- Encoding is applied at enqueue and stored in the entry:
  - Interrupt: io_interrupt = {26'b0, cause}, io_exception = 0.
  - Exception: io_exception = {26'b0, cause}, io_interrupt = 0.
  - For exceptions, hasNMI, hvictlInject, irToHS and irToVS are forced to 0.
  - io_exceptionPC = in_pc sign-extended from bit VADDR_BITS-1.
- FIFO storage:
  - Registered head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - Occupancy counter of log2(DEPTH)+1 bits.
  - Empty when the count is 0; full when the count equals DEPTH.
- Enqueue: when in_valid and (not full, or a dequeue occurs in the same cycle), write at tail and advance tail.
- Dequeue: when enable = 1, advance head.
- Occupancy update:
  - Enqueue and dequeue in the same cycle: count unchanged.
  - When full, a simultaneous dequeue plus enqueue is accepted; nothing is dropped.
- Latency: an event accepted in cycle N appears on io_* with io_valid = 1 in cycle N+1 at the earliest. The FIFO has no bypass.
- Output data:
  - When io_valid = 1, io_* show the head entry combinationally from storage.
  - When io_valid = 0, all io_* data fields read 0 except io_coreid.
- Ordering: strict FIFO; there is no coalescing of identical events.
- Drop (in_valid AND full AND NOT enable):
  - The event is discarded and overflow is set to 1.
  - drop_count increments by 1 and saturates at all-ones.
- overflow and drop_count are cleared only by reset.
- enable is never asserted without io_valid; out_ready while empty has no effect.
- Reset values: pointers, count, overflow, drop_count, io_valid and enable are 0; entry contents are don't-care but masked to 0 on the outputs.
- Reset mid-operation: all queued events are discarded. An in_valid in a reset cycle is ignored.

Test Plan:
- Reset, then single exception (cause 2, pc 0x2_0000_1000, VADDR_BITS 50), out_ready = 1:
  - Next cycle: enable = 1, io_exception = 2, io_interrupt = 0, io_exceptionPC = 0x0000_0002_0000_1000.
  - Following cycle: io_valid = 0.
- Interrupt (cause 7, in_hasNMI = 1, in_irToVS = 1):
  - io_interrupt = 7, io_exception = 0, io_hasNMI = 1, io_irToVS = 1.
  - Same flags on an exception → both read 0.
- PC sign extension: in_pc = 50'h2_0000_0000_0000 (bit 49 set) → io_exceptionPC = 64'hFFFE_0000_0000_0000.
- out_ready = 0 and 6 back-to-back events with DEPTH 4:
  - 4 queued, overflow = 1, drop_count = 2.
  - Then out_ready = 1 → 4 enable pulses in original order.
- Full FIFO with simultaneous in_valid and out_ready: count stays 4, drop_count unchanged, new event lands last.
- Reset asserted with 3 events queued → next cycle io_valid = 0, overflow = 0, drop_count = 0, and no enable pulse.

Source files
------------

// File: rtl/difftest_arch_event_queue.sv
// Trap-report encoder and small FIFO feeding the difftest arch-event sink.
// Events are encoded on capture so the drain side is a pure register read.
module difftest_arch_event_queue #(
    parameter int DEPTH      = 4,
    parameter int VADDR_BITS = 50,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_isInterrupt,
    input  logic [5:0]            in_cause,
    input  logic [VADDR_BITS-1:0] in_pc,
    input  logic [31:0]           in_inst,
    input  logic                  in_hasNMI,
    input  logic                  in_hvictlInject,
    input  logic                  in_irToHS,
    input  logic                  in_irToVS,
    input  logic [7:0]            in_coreid,
    input  logic                  out_ready,
    output logic                  enable,
    output logic                  io_valid,
    output logic [31:0]           io_interrupt,
    output logic [31:0]           io_exception,
    output logic [63:0]           io_exceptionPC,
    output logic [31:0]           io_exceptionInst,
    output logic                  io_hasNMI,
    output logic                  io_virtualInterruptIsHvictlInject,
    output logic                  io_irToHS,
    output logic                  io_irToVS,
    output logic [7:0]            io_coreid,
    output logic                  overflow,
    output logic [CNT_W-1:0]      drop_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] interrupt;
        logic [31:0] exception;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        has_nmi;
        logic        hvictl_inject;
        logic        ir_to_hs;
        logic        ir_to_vs;
    } entry_t;

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   count_reg;
    logic             overflow_reg;
    logic [CNT_W-1:0] drop_count_reg;
    entry_t           mem_reg [DEPTH];

    entry_t wr_entry;
    entry_t rd_entry;
    logic   full;
    logic   deq;
    logic   enq;
    logic   drop;

    always_comb begin
        wr_entry = '0;
        wr_entry.pc   = {{(64-VADDR_BITS){in_pc[VADDR_BITS-1]}}, in_pc};
        wr_entry.inst = in_inst;
        if (in_isInterrupt) begin
            wr_entry.interrupt     = {26'b0, in_cause};
            wr_entry.has_nmi       = in_hasNMI;
            wr_entry.hvictl_inject = in_hvictlInject;
            wr_entry.ir_to_hs      = in_irToHS;
            wr_entry.ir_to_vs      = in_irToVS;
        end else begin
            wr_entry.exception = {26'b0, in_cause};
        end
    end

    assign io_valid = (count_reg != '0);
    assign full     = (count_reg == FULL_COUNT);
    assign enable   = io_valid & out_ready;
    assign deq      = enable;
    // A full queue still takes a new event when the head leaves in the same cycle.
    assign enq      = in_valid & (~full | deq);
    assign drop     = in_valid & full & ~deq;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (enq && (tail_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= wr_entry;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            if (enq) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (deq) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            if (enq && !deq) begin
                count_reg <= count_reg + (PTR_W+1)'(1);
            end else if (deq && !enq) begin
                count_reg <= count_reg - (PTR_W+1)'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_count_reg != '1) begin
                    drop_count_reg <= drop_count_reg + CNT_W'(1);
                end
            end
        end
    end

    // Stale storage behind an empty queue must never leak onto the sink.
    assign rd_entry = io_valid ? mem_reg[head_reg] : '0;

    assign io_interrupt                      = rd_entry.interrupt;
    assign io_exception                      = rd_entry.exception;
    assign io_exceptionPC                    = rd_entry.pc;
    assign io_exceptionInst                  = rd_entry.inst;
    assign io_hasNMI                         = rd_entry.has_nmi;
    assign io_virtualInterruptIsHvictlInject = rd_entry.hvictl_inject;
    assign io_irToHS                         = rd_entry.ir_to_hs;
    assign io_irToVS                         = rd_entry.ir_to_vs;
    assign io_coreid                         = in_coreid;
    assign overflow                          = overflow_reg;
    assign drop_count                        = drop_count_reg;
endmodule
